// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } mdu_state_e;

    localparam int          MDU_ITERS = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit: one bit per cycle over a shared
// 64-bit accumulator, results committed to HI/LO only when the operation ends.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    mdu_state_e          state_reg, state_next;
    md_op_e              op_reg;
    logic [DATA_W-1:0]   a_reg, b_reg, hi_reg, lo_reg;
    logic                neg_q_reg, neg_r_reg, done_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [4:0]          cnt_reg;

    logic                is_div, signed_op, ge;
    logic [DATA_W:0]     trial, diff;
    logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign is_div    = (op_reg == MD_DIV) || (op_reg == MD_DIVU);
    assign signed_op = (op_reg == MD_MULT) || (op_reg == MD_DIV);

    // Both algorithms walk the operand bits MSB first, indexed by the counter,
    // so the accumulator can start from zero for either operation.
    always_comb begin
        trial    = {acc_reg[2*DATA_W-1:DATA_W], a_reg[cnt_reg]};
        diff     = trial - {1'b0, b_reg};
        ge       = ~diff[DATA_W];
        div_next = {(ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0]),
                    acc_reg[DATA_W-2:0], ge};
        mul_next = {acc_reg[2*DATA_W-2:0], 1'b0}
                 + (b_reg[cnt_reg] ? {{DATA_W{1'b0}}, a_reg} : '0);
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quo_fix  = neg_q_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
        rem_fix  = neg_r_reg ? -acc_reg[2*DATA_W-1:DATA_W]
                             : acc_reg[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_PREP;
            ST_PREP: state_next = ST_CALC;
            ST_CALC: if (cnt_reg == 5'd0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != ST_IDLE);
        done = done_reg;
        hi   = hi_reg;
        lo   = lo_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg    <= MD_MULT;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            done_reg  <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            done_reg <= (state_reg == ST_FIX);
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg <= md_op_e'(md_op);
                        a_reg  <= operand_a;
                        b_reg  <= operand_b;
                    end
                    if (hi_we) hi_reg <= wdata;
                    if (lo_we) lo_reg <= wdata;
                end
                ST_PREP: begin
                    if (signed_op) begin
                        a_reg     <= a_reg[DATA_W-1] ? -a_reg : a_reg;
                        b_reg     <= b_reg[DATA_W-1] ? -b_reg : b_reg;
                        neg_q_reg <= a_reg[DATA_W-1] ^ b_reg[DATA_W-1];
                        neg_r_reg <= a_reg[DATA_W-1];
                    end else begin
                        neg_q_reg <= 1'b0;
                        neg_r_reg <= 1'b0;
                    end
                    acc_reg <= '0;
                    cnt_reg <= 5'(MDU_ITERS - 1);
                end
                ST_CALC: begin
                    acc_reg <= is_div ? div_next : mul_next;
                    cnt_reg <= cnt_reg - 5'd1;
                end
                ST_FIX: begin
                    if (is_div) begin
                        // A zero divisor leaves the dividend as remainder;
                        // the quotient is forced so its sign cannot flip it.
                        hi_reg <= rem_fix;
                        lo_reg <= (b_reg == '0) ? DIV0_LO : quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
                        lo_reg <= prod_fix[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 The block SHALL have one parameter: DATA_W, default 32, operand/HI/LO width; only 32 is supported.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 Port md_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-007 Port operand_a  input  32  rs value (multiplicand / dividend); sampled with start.
REQ-008 Port operand_b  input  32  rt value (multiplier / divisor); sampled with start.
REQ-009 Port hi_we  input  1  MTHI write enable.
REQ-010 Port lo_we  input  1  MTLO write enable.
REQ-011 Port wdata  input  32  MTHI/MTLO write data.
REQ-012 Port busy  output  1  operation in progress; high in every state except IDLE.
REQ-013 Port done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-014 Port hi  output  32  HI register, read by MFHI.
REQ-015 Port lo  output  32  LO register, read by MFLO.

Function
REQ-016 The FSM SHALL have states IDLE, PREP, CALC and FIX.
REQ-017 IDLE with start=1 SHALL latch md_op/operands and go to PREP at the next edge; start outside IDLE SHALL be ignored.
REQ-018 PREP SHALL take operand magnitudes for MULT/DIV (unchanged for MULTU/DIVU), record the result sign(s), clear the 64-bit accumulator, load the 5-bit iteration counter with 31 and go to CALC.
REQ-019 CALC SHALL perform one step per cycle for exactly 32 cycles: shift-add for multiply, restoring shift-subtract for divide; counter 0 -> FIX.
REQ-020 FIX SHALL apply sign correction, write HI/LO, pulse done for one cycle and go to IDLE at the next edge.
REQ-021 done SHALL rise exactly 34 cycles after the start edge; HI/LO SHALL change at that same edge, and busy SHALL be low in the cycle done rises.
REQ-022 MULT/MULTU SHALL produce the full 64-bit product: {HI,LO} = signed/unsigned a*b.
REQ-023 DIV/DIVU SHALL produce LO=quotient and HI=remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-025 A divisor of 0 SHALL give HI=operand_a and LO=0xFFFFFFFF with unchanged latency; no exception is raised.
REQ-026 hi_we/lo_we in IDLE SHALL write wdata to HI/LO at the next edge; while busy they SHALL be ignored.
REQ-027 If hi_we/lo_we coincide with the FIX write, the FIX result SHALL win.
REQ-028 hi/lo SHALL hold their previous values throughout an operation, with no partial results visible.
REQ-029 Back-to-back: start may be asserted in the cycle done is high and SHALL be accepted.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and accumulator.
REQ-031 Reset mid-operation SHALL abandon the operation; no done SHALL follow.

Structure
REQ-032 A shared package mdu_pkg SHALL hold the md_op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the state enum, MDU_ITERS=32 and DIV0_LO=32'hFFFF_FFFF.
REQ-033 The block SHALL be a single module with no sub-module; multiply and divide share one 64-bit accumulator and one counter.

Verification
REQ-034 MULT a=0xFFFFFFFD (-3), b=7 -> done at cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100, b=0 -> HI=0x64, LO=0xFFFFFFFF.
REQ-037 MTHI 0x1234 in IDLE, then start DIVU 9/4 with hi_we pulsed at cycle 10 -> hi=0x1234 until done, then HI=1, LO=2.
REQ-038 Start MULT 5*5, assert rst_n=0 at cycle 20 -> busy=0, hi=lo=0 immediately; no done within 40 cycles after release.
